// File: rtl/mem_arbiter_if.sv
// Bus bundle for the memory arbiter: fetch port, data port, shared-memory
// port and the status outputs. The arbiter uses the slave view; whatever
// sits around it (core pipeline and memory) uses the master view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    // instruction-fetch port
    logic                  if_req_in;
    logic [DATA_WIDTH-1:0] if_addr_in;
    logic [DATA_WIDTH-1:0] if_data_out;
    logic                  if_ack_out;
    // data port
    logic                  dm_req_in;
    logic                  dm_write_in;
    logic [DATA_WIDTH-1:0] dm_addr_in;
    logic [DATA_WIDTH-1:0] dm_wdata_in;
    logic [DATA_WIDTH-1:0] dm_rdata_out;
    logic                  dm_ack_out;
    // shared single-port memory
    logic                  mem_req_out;
    logic                  mem_write_out;
    logic [DATA_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_wdata_out;
    logic [DATA_WIDTH-1:0] mem_rdata_in;
    logic                  mem_ready_in;
    // status
    logic                  stall_out;
    logic                  err_out;

    modport slave (
        input  if_req_in, if_addr_in,
        output if_data_out, if_ack_out,
        input  dm_req_in, dm_write_in, dm_addr_in, dm_wdata_in,
        output dm_rdata_out, dm_ack_out,
        output mem_req_out, mem_write_out, mem_addr_out, mem_wdata_out,
        input  mem_rdata_in, mem_ready_in,
        output stall_out, err_out
    );

    modport master (
        output if_req_in, if_addr_in,
        input  if_data_out, if_ack_out,
        output dm_req_in, dm_write_in, dm_addr_in, dm_wdata_in,
        input  dm_rdata_out, dm_ack_out,
        input  mem_req_out, mem_write_out, mem_addr_out, mem_wdata_out,
        output mem_rdata_in, mem_ready_in,
        input  stall_out, err_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a shared single-port memory.
// Data port has priority; a saturating starvation counter forces the fetch
// port through after STARVE_MAX consecutive losses. Every transaction has a
// MAX_WAIT-cycle watchdog that completes it with zero data and a sticky error.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset_in,
    mem_arbiter_if.slave  bus
);
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LIM   = WAIT_W'(MAX_WAIT);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    mem_req_q;
    logic                    mem_write_q;
    logic [DATA_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   if_data_q;
    logic [DATA_WIDTH-1:0]   dm_data_q;
    logic                    if_ack_q;
    logic                    dm_ack_q;
    logic                    err_q;
    logic [WAIT_W-1:0]       wait_q;
    logic [STARVE_W-1:0]     starve_q;

    logic [WAIT_W-1:0]       wait_d;
    logic [STARVE_W-1:0]     starve_d;
    logic                    grant_if;
    logic                    grant_dm;
    logic                    timeout;

    // Arbitration and watchdog decode. No grant is made in a cycle where
    // either ack is high: the requester that just completed is still
    // holding its request, and keeping the other port waiting one cycle
    // lets back-to-back data requests build up the starvation count so the
    // fetch port is only forced through once STARVE_MAX is reached.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == IDLE && !if_ack_q && !dm_ack_q) begin
            if (bus.if_req_in && (!bus.dm_req_in || starve_q == STARVE_LIM))
                grant_if = 1'b1;
            else if (bus.dm_req_in)
                grant_dm = 1'b1;
        end
        starve_d = starve_q;
        if (grant_dm && bus.if_req_in && starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
        wait_d  = wait_q + 1'b1;
        timeout = (wait_d == WAIT_LIM) && !bus.mem_ready_in;
    end

    // Main FSM: grants, memory request registers, completion and timeout.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_data_q   <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            starve_q    <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // mem_ready_in is deliberately not looked at here
                    if (grant_if) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= bus.if_addr_in;
                        mem_wdata_q <= '0;
                        wait_q      <= '0;
                        starve_q    <= '0;
                    end else if (grant_dm) begin
                        state_q     <= BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_write_q <= bus.dm_write_in;
                        mem_addr_q  <= bus.dm_addr_in;
                        mem_wdata_q <= bus.dm_wdata_in;
                        wait_q      <= '0;
                        starve_q    <= starve_d;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // a real completion wins over a watchdog expiry on the same edge
                    if (bus.mem_ready_in || timeout) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        if (timeout)
                            err_q <= 1'b1;
                        if (state_q == BUSY_IF) begin
                            if_ack_q  <= 1'b1;
                            if_data_q <= timeout ? '0 : bus.mem_rdata_in;
                        end else begin
                            dm_ack_q <= 1'b1;
                            // stores leave the load data register alone
                            if (timeout)
                                dm_data_q <= '0;
                            else if (!mem_write_q)
                                dm_data_q <= bus.mem_rdata_in;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_out   = mem_req_q;
    assign bus.mem_write_out = mem_write_q;
    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.mem_wdata_out = mem_wdata_q;
    assign bus.if_data_out   = if_data_q;
    assign bus.if_ack_out    = if_ack_q;
    assign bus.dm_rdata_out  = dm_data_q;
    assign bus.dm_ack_out    = dm_ack_q;
    assign bus.err_out       = err_q;
    // Stall holds the pipeline while any request is outstanding; it drops in
    // the ack cycle so the pipeline can advance on that same edge.
    assign bus.stall_out     = (bus.if_req_in && !if_ack_q) || (bus.dm_req_in && !dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// completions; a monitor pops and compares on every ack.
module tb_mem_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_in;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW)) bus();

    mem_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(15), .STARVE_MAX(3)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_dm;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    bit mem_hang   = 1'b0;
    bit idle_ready = 1'b0;
    int mem_lat    = 0;
    int busy_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input bit is_dm, input logic [31:0] d);
        exp_t e;
        e.is_dm = is_dm;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input bit is_dm, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack port_dm=%0d actual=%h required=no_ack", is_dm, d);
        end else begin
            e = sb.pop_front();
            chk(is_dm ? "dm_ack_data" : "if_ack_data", d, e.data);
            chk("ack_port_is_dm", 32'(is_dm), 32'(e.is_dm));
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8C02_0004;
            32'h44:  return 32'h0085_1020;
            32'h100: return 32'h1234_5678;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // memory model: ready mem_lat cycles after mem_req_out rises
    initial begin
        bus.mem_ready_in = 1'b0;
        bus.mem_rdata_in = '0;
        forever begin
            @(negedge clk);
            if (!bus.mem_req_out) begin
                busy_cnt         = 0;
                bus.mem_ready_in = idle_ready;
                bus.mem_rdata_in = idle_ready ? 32'hFFFF_FFFF : 32'h0;
            end else if (mem_hang) begin
                bus.mem_ready_in = 1'b0;
            end else if (busy_cnt >= mem_lat) begin
                bus.mem_ready_in = 1'b1;
                bus.mem_rdata_in = mem_rd(bus.mem_addr_out);
            end else begin
                bus.mem_ready_in = 1'b0;
                busy_cnt++;
            end
        end
    end

    // monitor: every ack pops one expectation
    initial begin
        forever begin
            @(negedge clk);
            if (bus.if_ack_out && bus.dm_ack_out)
                chk("dual_ack", 32'd1, 32'd0);
            if (bus.if_ack_out) pop_cmp(1'b0, bus.if_data_out);
            if (bus.dm_ack_out) pop_cmp(1'b1, bus.dm_rdata_out);
        end
    end

    task automatic req_if(input logic [31:0] addr, output int cyc,
                          output logic [31:0] maddr, output logic mwr);
        bit got = 1'b0;
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = addr;
        cyc = 0; maddr = 'x; mwr = 1'bx;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin maddr = bus.mem_addr_out; mwr = bus.mem_write_out; end
            if (bus.if_ack_out) got = 1'b1;
        end
        bus.if_req_in = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL if_ack_timeout actual=no_ack required=ack addr=%h", addr);
        end
    endtask

    task automatic req_dm(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit scramble, output int cyc, output logic [31:0] maddr,
                          output logic mwr, output logic [31:0] mwdata);
        bit got = 1'b0;
        int cap = scramble ? 3 : 1;
        bus.dm_req_in   = 1'b1;
        bus.dm_write_in = wr;
        bus.dm_addr_in  = addr;
        bus.dm_wdata_in = wdata;
        cyc = 0; maddr = 'x; mwr = 1'bx; mwdata = 'x;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == cap) begin
                maddr = bus.mem_addr_out; mwr = bus.mem_write_out; mwdata = bus.mem_wdata_out;
            end
            if (scramble && cyc == 2) begin
                bus.dm_addr_in  = ~addr;
                bus.dm_wdata_in = ~wdata;
                bus.dm_write_in = ~wr;
            end
            if (bus.dm_ack_out) got = 1'b1;
        end
        bus.dm_req_in = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL dm_ack_timeout actual=no_ack required=ack addr=%h", addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1, c2, n;
        logic [31:0] ma, mwd;
        logic mw;
        bit if_done;

        reset_in        = 1'b1;
        bus.if_req_in   = 1'b0;
        bus.if_addr_in  = '0;
        bus.dm_req_in   = 1'b0;
        bus.dm_write_in = 1'b0;
        bus.dm_addr_in  = '0;
        bus.dm_wdata_in = '0;
        repeat (2) @(negedge clk);

        chk("rst_mem_req",   32'(bus.mem_req_out),   32'd0);
        chk("rst_mem_write", 32'(bus.mem_write_out), 32'd0);
        chk("rst_mem_addr",  bus.mem_addr_out,       32'd0);
        chk("rst_if_ack",    32'(bus.if_ack_out),    32'd0);
        chk("rst_dm_ack",    32'(bus.dm_ack_out),    32'd0);
        chk("rst_err",       32'(bus.err_out),       32'd0);
        chk("rst_stall",     32'(bus.stall_out),     32'd0);
        reset_in = 1'b0;
        @(negedge clk);

        // single fetch, 2-cycle latency
        push(1'b0, 32'h8C02_0004);
        req_if(32'h40, c1, ma, mw);
        chk("fetch_latency", 32'(c1), 32'd2);
        chk("fetch_mem_addr", ma, 32'h40);
        chk("fetch_mem_write", 32'(mw), 32'd0);
        @(negedge clk);
        chk("fetch_ack_one_cycle", 32'(bus.if_ack_out), 32'd0);

        // memory ready while idle must not complete anything
        idle_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready_no_ack", 32'({bus.if_ack_out, bus.dm_ack_out}), 32'd0);
        end
        chk("idle_ready_if_data", bus.if_data_out, 32'h8C02_0004);
        idle_ready = 1'b0;
        @(negedge clk);

        // simultaneous load 0x100 and fetch 0x44: data first, stall until fetch ack
        push(1'b1, 32'h1234_5678);
        push(1'b0, 32'h0085_1020);
        if_done = 1'b0;
        n = 0;
        fork
            begin req_dm(1'b0, 32'h100, 32'h0, 1'b0, c1, ma, mw, mwd); end
            begin req_if(32'h44, c2, ma, mw); if_done = 1'b1; end
            begin
                while (!if_done && n < 50) begin
                    @(negedge clk); #1;
                    if (!if_done) chk("stall_while_pending", 32'(bus.stall_out), 32'd1);
                    n++;
                end
            end
        join
        chk("simul_dm_latency", 32'(c1), 32'd2);
        chk("simul_if_latency", 32'(c2), 32'd5);
        chk("stall_cleared", 32'(bus.stall_out), 32'd0);
        @(negedge clk);

        // store: load data register untouched
        push(1'b1, 32'h1234_5678);
        req_dm(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, c1, ma, mw, mwd);
        chk("store_latency", 32'(c1), 32'd2);
        chk("store_mem_addr", ma, 32'h10);
        chk("store_mem_write", 32'(mw), 32'd1);
        chk("store_mem_wdata", mwd, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("store_rdata_hold", bus.dm_rdata_out, 32'h1234_5678);

        // mem_* stable while requester inputs change mid-BUSY
        mem_lat = 3;
        push(1'b1, 32'h5A5A_0080);
        req_dm(1'b0, 32'h80, 32'h0, 1'b1, c1, ma, mw, mwd);
        chk("stable_latency", 32'(c1), 32'd5);
        chk("stable_mem_addr", ma, 32'h80);
        chk("stable_mem_write", 32'(mw), 32'd0);
        chk("stable_mem_wdata", mwd, 32'h0);
        mem_lat = 0;
        @(negedge clk);

        // starvation: continuous stores vs held fetch -> dm,dm,dm,if,dm
        push(1'b1, 32'h5A5A_0080);
        push(1'b1, 32'h5A5A_0080);
        push(1'b1, 32'h5A5A_0080);
        push(1'b0, 32'h5A5A_0048);
        push(1'b1, 32'h5A5A_0080);
        fork
            begin req_if(32'h48, c2, ma, mw); end
            begin
                for (int k = 0; k < 4; k++)
                    req_dm(1'b1, 32'h20 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0, c1, ma, mw, mwd);
            end
        join
        chk("starve_if_latency", 32'(c2), 32'd11);
        @(negedge clk);

        // timeout on a load, then normal service with sticky error
        chk("err_before_timeout", 32'(bus.err_out), 32'd0);
        mem_hang = 1'b1;
        push(1'b1, 32'h0);
        req_dm(1'b0, 32'h200, 32'h0, 1'b0, c1, ma, mw, mwd);
        chk("timeout_latency", 32'(c1), 32'd16);
        chk("timeout_err", 32'(bus.err_out), 32'd1);
        mem_hang = 1'b0;
        @(negedge clk);
        push(1'b1, 32'h5A5A_0104);
        req_dm(1'b0, 32'h104, 32'h0, 1'b0, c1, ma, mw, mwd);
        chk("after_timeout_latency", 32'(c1), 32'd2);
        chk("err_sticky", 32'(bus.err_out), 32'd1);
        @(negedge clk);

        // asynchronous reset in the middle of a data transaction
        mem_hang        = 1'b1;
        bus.dm_req_in   = 1'b1;
        bus.dm_write_in = 1'b0;
        bus.dm_addr_in  = 32'h300;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", 32'(bus.mem_req_out), 32'd1);
        #2 reset_in = 1'b1;
        #1;
        chk("async_rst_mem_req",  32'(bus.mem_req_out),  32'd0);
        chk("async_rst_mem_addr", bus.mem_addr_out,      32'd0);
        chk("async_rst_dm_rdata", bus.dm_rdata_out,      32'd0);
        chk("async_rst_if_data",  bus.if_data_out,       32'd0);
        chk("async_rst_err",      32'(bus.err_out),      32'd0);
        bus.dm_req_in = 1'b0;
        mem_hang      = 1'b0;
        repeat (2) @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        push(1'b1, 32'h1234_5678);
        req_dm(1'b0, 32'h100, 32'h0, 1'b0, c1, ma, mw, mwd);
        chk("post_reset_latency", 32'(c1), 32'd2);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
